// File: rtl/sido_adc_sequencer.sv
// Shares one ADC between the 5V and 3V3 SIDO rails and turns each sample into error/request/emergency signals.
// Optional macro SIDO_ADC_AVG_EN: the error is taken from the average of this sample and the rail's previous raw sample.
module sido_adc_sequencer #(
  parameter int               ADC_W      = 12,
  parameter logic [ADC_W-1:0] REF_5V     = 12'd3103,
  parameter logic [ADC_W-1:0] REF_3V3    = 12'd2048,
  parameter int               HYST       = 8,
  parameter int               EMERG_TH   = 150,
  parameter int               EMERG_CNT  = 4,
  parameter int               SETTLE_CYC = 4,
  parameter int               TIMEOUT    = 63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             adc_start,
  output logic             adc_ch,
  input  logic             adc_done,
  input  logic [ADC_W-1:0] adc_data,
  output logic [12:0]      error_3v3,
  output logic [12:0]      error_5v,
  output logic             request_3V3,
  output logic             request_5V,
  output logic             emergency_3v3,
  output logic             emergency_5v,
  output logic             sample_valid,
  output logic             adc_timeout
);

  localparam int CW  = $clog2(TIMEOUT + 2);
  localparam int ECW = $clog2(EMERG_CNT + 1);
  localparam logic signed [12:0] HYST_S  = 13'(HYST);
  localparam logic signed [12:0] NHYST_S = -HYST_S;
  localparam logic signed [12:0] TH_S    = 13'(EMERG_TH);
  localparam logic signed [12:0] HALF_S  = 13'(EMERG_TH / 2);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CONVERT, S_UPDATE} state_t;

  function automatic logic signed [12:0] calc_err(input logic [ADC_W-1:0] refc,
                                                  input logic [ADC_W-1:0] smp);
    calc_err = $signed(13'(refc)) - $signed(13'(smp));
  endfunction

  function automatic logic [ECW-1:0] sat_inc(input logic [ECW-1:0] c);
    sat_inc = (c >= ECW'(EMERG_CNT)) ? c : c + ECW'(1);
  endfunction

  state_t                   r_state, w_next;
  logic [CW-1:0]            r_cnt, w_cnt_nxt;
  logic                     w_start, w_capture, w_timeout, w_update;
  logic [ADC_W-1:0]         r_sample, w_val, w_ref;
  logic                     r_ch, r_valid, r_timeout;
  logic signed [12:0]       r_err_3v3, r_err_5v, w_err;
  logic                     r_req_3v3, r_req_5v, r_em_3v3, r_em_5v;
  logic [ECW-1:0]           r_ecnt_3v3, r_ecnt_5v, w_ecnt_cur, w_ecnt_new;
  logic                     w_req_cur, w_req_new, w_em_cur, w_em_new;

  // Control FSM: one counter serves both the settle delay and the conversion wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_start   = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    w_update  = 1'b0;
    if (!enable) begin
      w_next    = S_IDLE;
      w_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_next    = S_SETTLE;
          w_cnt_nxt = '0;
        end
        S_SETTLE: begin
          if (r_cnt == CW'(SETTLE_CYC - 1)) begin
            w_next    = S_CONVERT;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_CONVERT: begin
          // adc_done in the start cycle belongs to nothing we asked for.
          w_start = (r_cnt == '0);
          if ((r_cnt != '0) && adc_done) begin
            w_capture = 1'b1;
            w_next    = S_UPDATE;
            w_cnt_nxt = '0;
          end else if (r_cnt == CW'(TIMEOUT + 1)) begin
            w_timeout = 1'b1;
            w_next    = S_SETTLE;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_UPDATE: begin
          w_update  = 1'b1;
          w_next    = S_SETTLE;
          w_cnt_nxt = '0;
        end
        default: begin
          w_next    = S_IDLE;
          w_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Capture stage: raw sample held for the UPDATE cycle.
  always_ff @(posedge clk) begin
    if (w_capture) r_sample <= adc_data;
  end

`ifdef SIDO_ADC_AVG_EN
  logic [ADC_W-1:0] r_prev_3v3, r_prev_5v;
  logic             r_seen_3v3, r_seen_5v;
  logic [ADC_W:0]   w_sum;

  always_ff @(posedge clk) begin
    if (w_update) begin
      if (r_ch) r_prev_5v  <= r_sample;
      else      r_prev_3v3 <= r_sample;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seen_3v3 <= 1'b0;
      r_seen_5v  <= 1'b0;
    end else if (w_update) begin
      if (r_ch) r_seen_5v  <= 1'b1;
      else      r_seen_3v3 <= 1'b1;
    end
  end

  assign w_sum = {1'b0, r_sample} + {1'b0, (r_ch ? r_prev_5v : r_prev_3v3)};
  assign w_val = (r_ch ? r_seen_5v : r_seen_3v3) ? ADC_W'(w_sum >> 1) : r_sample;
`else
  assign w_val = r_sample;
`endif

  assign w_ref = r_ch ? REF_5V : REF_3V3;
  assign w_err = calc_err(w_ref, w_val);

  always_comb begin
    w_req_cur  = r_ch ? r_req_5v  : r_req_3v3;
    w_em_cur   = r_ch ? r_em_5v   : r_em_3v3;
    w_ecnt_cur = r_ch ? r_ecnt_5v : r_ecnt_3v3;
    w_req_new  = w_req_cur;
    if (w_err >= HYST_S)       w_req_new = 1'b1;
    else if (w_err <= NHYST_S) w_req_new = 1'b0;
    w_ecnt_new = (w_err > TH_S) ? sat_inc(w_ecnt_cur) : '0;
    w_em_new   = w_em_cur;
    if (w_ecnt_new == ECW'(EMERG_CNT)) w_em_new = 1'b1;
    else if (w_err <= HALF_S)          w_em_new = 1'b0;
  end

  // Update stage: only the sampled rail changes; disable drops requests and emergencies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ch       <= 1'b0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
      r_err_3v3  <= '0;
      r_err_5v   <= '0;
      r_req_3v3  <= 1'b0;
      r_req_5v   <= 1'b0;
      r_em_3v3   <= 1'b0;
      r_em_5v    <= 1'b0;
      r_ecnt_3v3 <= '0;
      r_ecnt_5v  <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_timeout) r_timeout <= 1'b1;
      if (!enable) begin
        r_req_3v3 <= 1'b0;
        r_req_5v  <= 1'b0;
        r_em_3v3  <= 1'b0;
        r_em_5v   <= 1'b0;
      end else if (w_update) begin
        r_valid <= 1'b1;
        r_ch    <= ~r_ch;
        if (r_ch) begin
          r_err_5v  <= w_err;
          r_req_5v  <= w_req_new;
          r_ecnt_5v <= w_ecnt_new;
          r_em_5v   <= w_em_new;
        end else begin
          r_err_3v3  <= w_err;
          r_req_3v3  <= w_req_new;
          r_ecnt_3v3 <= w_ecnt_new;
          r_em_3v3   <= w_em_new;
        end
      end
    end
  end

  assign adc_start     = w_start;
  assign adc_ch        = r_ch;
  assign error_3v3     = r_err_3v3;
  assign error_5v      = r_err_5v;
  assign request_3V3   = r_req_3v3;
  assign request_5V    = r_req_5v;
  assign emergency_3v3 = r_em_3v3;
  assign emergency_5v  = r_em_5v;
  assign sample_valid  = r_valid;
  assign adc_timeout   = r_timeout;

endmodule

// File: tb/tb_sido_adc_sequencer.sv
// Directed bench for sido_adc_sequencer (default build): rail sequence, hysteresis, emergency, timeout, disable, reset.
module tb_sido_adc_sequencer;

  localparam int SETTLE_CYC = 4;

  logic        clk, reset, enable;
  logic        adc_start, adc_ch, adc_done;
  logic [11:0] adc_data;
  logic [12:0] error_3v3, error_5v;
  logic        request_3V3, request_5V, emergency_3v3, emergency_5v;
  logic        sample_valid, adc_timeout;

  int n_tot, n_bad;
  int e3, e5;

  // Sample sequence alternates 3V3 (even index) and 5V (odd index).
  int tv_d   [26] = '{2000, 2900, 2044, 2900, 2060, 2900, 2048, 2900, 2040, 3050, 2055, 3111, 2056,
                      2952, 1800, 2952, 1800, 2952, 1800, 2952, 1800, 3003, 1900, 3028, 1900, 2953};
  int tv_err [26] = '{48, 203, 4, 203, -12, 203, 0, 203, 8, 53, -7, -8, -8,
                      151, 248, 151, 248, 151, 248, 151, 248, 100, 148, 75, 148, 150};
  int tv_req [26] = '{1, 1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0,
                      1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  int tv_em  [26] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0};

  sido_adc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .adc_start     (adc_start),
    .adc_ch        (adc_ch),
    .adc_done      (adc_done),
    .adc_data      (adc_data),
    .error_3v3     (error_3v3),
    .error_5v      (error_5v),
    .request_3V3   (request_3V3),
    .request_5V    (request_5V),
    .emergency_3v3 (emergency_3v3),
    .emergency_5v  (emergency_5v),
    .sample_valid  (sample_valid),
    .adc_timeout   (adc_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no_finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic finish_up();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (adc_start) return;
    end
    chk("start_wait", 0, 1);
    finish_up();
  endtask

  // Called in the adc_start cycle; returns in the cycle the new outputs are visible.
  task automatic finish_conv(input logic [11:0] d, input bit early);
    if (early) begin
      adc_done = 1'b1;
      adc_data = 12'hFFF;
    end
    @(posedge clk); #1;
    adc_done = 1'b0;
    adc_data = '0;
    @(posedge clk); #1;
    adc_done = 1'b1;
    adc_data = d;
    @(posedge clk); #1;
    adc_done = 1'b0;
    adc_data = '0;
    chk("sv_early", int'(sample_valid), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_rail(input string t, input int ch, input int e_err, input int e_req,
                          input int e_em, input int e_other);
    if (ch == 0) begin
      chk({t, "_err3"}, int'($signed(error_3v3)), e_err);
      chk({t, "_req3"}, int'(request_3V3), e_req);
      chk({t, "_em3"},  int'(emergency_3v3), e_em);
      chk({t, "_err5"}, int'($signed(error_5v)), e_other);
    end else begin
      chk({t, "_err5"}, int'($signed(error_5v)), e_err);
      chk({t, "_req5"}, int'(request_5V), e_req);
      chk({t, "_em5"},  int'(emergency_5v), e_em);
      chk({t, "_err3"}, int'($signed(error_3v3)), e_other);
    end
    chk({t, "_sv"}, int'(sample_valid), 1);
    chk({t, "_ch"}, int'(adc_ch), 1 - ch);
  endtask

  initial begin
    int n, to_k, st_k;
    bit saw, svs;
    n_tot = 0; n_bad = 0; e3 = 0; e5 = 0;
    reset = 1'b1; enable = 1'b1; adc_done = 1'b0; adc_data = '0;

    saw = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (adc_start) saw = 1;
    end
    chk("rst_start", int'(saw), 0);
    chk("rst_ch",    int'(adc_ch), 0);
    chk("rst_err3",  int'(error_3v3), 0);
    chk("rst_err5",  int'(error_5v), 0);
    chk("rst_req",   int'({request_3V3, request_5V}), 0);
    chk("rst_em",    int'({emergency_3v3, emergency_5v}), 0);
    chk("rst_sv",    int'(sample_valid), 0);
    chk("rst_to",    int'(adc_timeout), 0);
    #3 reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      wait_start(n);
      if (i > 0) chk($sformatf("settle_%0d", i), n, SETTLE_CYC - 1);
      chk($sformatf("chpre_%0d", i), int'(adc_ch), i % 2);
      finish_conv(12'(tv_d[i]), i < 2);
      if (i % 2 == 0) begin
        chk_rail($sformatf("s%0d", i), 0, tv_err[i], tv_req[i], tv_em[i], e5);
        e3 = tv_err[i];
      end else begin
        chk_rail($sformatf("s%0d", i), 1, tv_err[i], tv_req[i], tv_em[i], e3);
        e5 = tv_err[i];
      end
      @(posedge clk); #1;
      chk($sformatf("sv_off_%0d", i), int'(sample_valid), 0);
    end

    // Timeout: no adc_done at all on this 3V3 conversion.
    wait_start(n);
    chk("to_chpre", int'(adc_ch), 0);
    svs = 0; to_k = -1; st_k = -1;
    for (int k = 1; k <= 90; k++) begin
      @(posedge clk); #1;
      if (sample_valid) svs = 1;
      if (k == 60) chk("to_early", int'(adc_timeout), 0);
      if (adc_timeout && to_k < 0) to_k = k;
      if (adc_start) begin
        st_k = k;
        break;
      end
    end
    if (st_k < 0) begin
      chk("to_restart", 0, 1);
      finish_up();
    end
    chk("to_set",   int'(adc_timeout), 1);
    chk("to_when",  int'(to_k >= 64 && to_k <= 66), 1);
    chk("to_retry", st_k - to_k, SETTLE_CYC);
    chk("to_ch",    int'(adc_ch), 0);
    chk("to_nosv",  int'(svs), 0);
    chk("to_hold3", int'($signed(error_3v3)), e3);
    chk("to_req3",  int'(request_3V3), 1);
    finish_conv(12'd1800, 1'b0);
    chk_rail("retry", 0, 248, 1, 1, e5);
    e3 = 248;
    chk("retry_to", int'(adc_timeout), 1);
    @(posedge clk); #1;

    // Disable in the middle of a 5V conversion; a late adc_done must be ignored.
    wait_start(n);
    chk("dis_chpre", int'(adc_ch), 1);
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    adc_done = 1'b1;
    adc_data = '0;
    svs = 0; saw = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      adc_done = 1'b0;
      if (sample_valid) svs = 1;
      if (adc_start) saw = 1;
    end
    chk("dis_nosv",  int'(svs), 0);
    chk("dis_nost",  int'(saw), 0);
    chk("dis_req3",  int'(request_3V3), 0);
    chk("dis_req5",  int'(request_5V), 0);
    chk("dis_em3",   int'(emergency_3v3), 0);
    chk("dis_em5",   int'(emergency_5v), 0);
    chk("dis_err3",  int'($signed(error_3v3)), e3);
    chk("dis_err5",  int'($signed(error_5v)), e5);
    chk("dis_ch",    int'(adc_ch), 1);
    chk("dis_to",    int'(adc_timeout), 1);

    enable = 1'b1;
    wait_start(n);
    chk("en_chpre", int'(adc_ch), 1);
    finish_conv(12'd3103, 1'b0);
    chk_rail("en5", 1, 0, 0, 0, e3);
    e5 = 0;
    @(posedge clk); #1;
    wait_start(n);
    finish_conv(12'd2000, 1'b0);
    chk_rail("en3", 0, 48, 1, 0, e5);
    e3 = 48;
    @(posedge clk); #1;

    // Asynchronous reset while a conversion is in flight.
    wait_start(n);
    chk("ar_chpre", int'(adc_ch), 1);
    #3 reset = 1'b1;
    #1;
    chk("ar_ch",    int'(adc_ch), 0);
    chk("ar_start", int'(adc_start), 0);
    chk("ar_err3",  int'(error_3v3), 0);
    chk("ar_req3",  int'(request_3V3), 0);
    chk("ar_to",    int'(adc_timeout), 0);
    #20;
    finish_up();
  end

endmodule
